// File: rtl/key_pkg.sv
// Shared types and constants for the push-button debouncer.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } key_state_t;

   // Channel assignment on the stopwatch board
   localparam int KEY_RESET        = 0;
   localparam int KEY_START_PAUSE  = 1;
   localparam int KEY_DISPLAY_STOP = 2;

   // Defaults for a 50 MHz clk: 10 ms debounce, 1 s long press
   localparam int NUM_KEYS_DEF        = 3;
   localparam int DEBOUNCE_CYCLES_DEF = 500000;
   localparam int LONG_CYCLES_DEF     = 50000000;

   // Timer width wide enough to hold the larger of the two terminal counts
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key bundle between the raw board buttons and the debouncer outputs.
interface key_debounce_if #(
   parameter int NUM_KEYS = 3
);
   logic [NUM_KEYS-1:0] key_n;
   logic [NUM_KEYS-1:0] key_press;
   logic [NUM_KEYS-1:0] key_release;
   logic [NUM_KEYS-1:0] key_level;
   logic [NUM_KEYS-1:0] key_long;

   modport master (
      output key_n,
      input  key_press,
      input  key_release,
      input  key_level,
      input  key_long
   );

   modport slave (
      input  key_n,
      output key_press,
      output key_release,
      output key_level,
      output key_long
   );
endinterface

// File: rtl/key_debounce_ch.sv
// One debounced key channel: synchronizer, accept/release FSM with a
// down-counting debounce timer, registered event outputs.
// Optional long-press detection is built when KEY_LONG_PRESS_EN is defined.
//
// state        | meaning
// IDLE         | key released and stable
// PRESS_WAIT   | key seen low, timing the press debounce window
// HELD         | press accepted, key_level = 1
// RELEASE_WAIT | key seen high while held, timing the release window
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_press,
   output logic key_release,
   output logic key_level,
   output logic key_long
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
   localparam logic [CW-1:0] DB_LOAD = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0] sync_q, sync_d;
   logic       key_sync;

   key_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic press_q, press_d;
   logic release_q, release_d;
   logic level_q, level_d;

   // Two-stage synchronizer; idles at 1 (released)
   always_comb begin
      sync_d = {sync_q[0], key_n};
   end

   assign key_sync = sync_q[1];

   // Next state; the timer is loaded with DEBOUNCE_CYCLES-1 on window
   // entry and the change is accepted when it has counted down to zero
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      level_d   = level_q;
      case (state_q)
         IDLE: begin
            if (!key_sync) begin
               state_d = PRESS_WAIT;
               cnt_d   = DB_LOAD;
            end
         end
         PRESS_WAIT: begin
            if (key_sync) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = HELD;
               press_d = 1'b1;
               level_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HELD: begin
            if (key_sync) begin
               state_d = RELEASE_WAIT;
               cnt_d   = DB_LOAD;
            end
         end
         RELEASE_WAIT: begin
            if (!key_sync) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d   = IDLE;
               release_d = 1'b1;
               level_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   // Synchronizer, FSM, timer and event registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= 2'b11;
         state_q   <= IDLE;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         level_q   <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         level_q   <= level_d;
      end
   end

   assign key_press   = press_q;
   assign key_release = release_q;
   assign key_level   = level_q;

`ifdef KEY_LONG_PRESS_EN
   localparam logic [CW-1:0] LONG_LOAD = CW'(LONG_CYCLES - 1);

   logic [CW-1:0] hold_q, hold_d;
   logic long_done_q, long_done_d;
   logic long_q, long_d;

   // Hold timer: restarts on each accepted press, runs only in HELD so a
   // release bounce pauses it; long_done keeps it to one event per press
   always_comb begin
      hold_d      = hold_q;
      long_done_d = long_done_q;
      long_d      = 1'b0;
      if (press_d) begin
         hold_d      = LONG_LOAD;
         long_done_d = 1'b0;
      end else if (state_q == HELD) begin
         if (hold_q == '0) begin
            if (!long_done_q) begin
               long_d      = 1'b1;
               long_done_d = 1'b1;
            end
         end else begin
            hold_d = hold_q - 1'b1;
         end
      end
   end

   // Hold timer and long-press event registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q      <= '0;
         long_done_q <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         long_done_q <= long_done_d;
         long_q      <= long_d;
      end
   end

   assign key_long = long_q;
`else
   assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner for the stopwatch: NUM_KEYS independent
// debounced channels producing press/release/long pulses and held level.
// Long-press events are built only when KEY_LONG_PRESS_EN is defined.
module key_debounce
   import key_pkg::*;
#(
   parameter int NUM_KEYS        = NUM_KEYS_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input logic           clk,
   input logic           rst_n,
   key_debounce_if.slave kif
);

   logic [NUM_KEYS-1:0] press_w;
   logic [NUM_KEYS-1:0] release_w;
   logic [NUM_KEYS-1:0] level_w;
   logic [NUM_KEYS-1:0] long_w;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .key_n       (kif.key_n[i]),
         .key_press   (press_w[i]),
         .key_release (release_w[i]),
         .key_level   (level_w[i]),
         .key_long    (long_w[i])
      );
   end

   assign kif.key_press   = press_w;
   assign kif.key_release = release_w;
   assign kif.key_level   = level_w;
   assign kif.key_long    = long_w;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
// Expected outputs come from a run-length model of the debounce rules.
module tb_key_debounce;
   import key_pkg::*;

   localparam int D  = 4;
   localparam int L  = 10;
   localparam int NK = 3;
`ifdef KEY_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   key_debounce_if #(.NUM_KEYS(NK)) kif ();

   key_debounce #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (D),
      .LONG_CYCLES     (L)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kif   (kif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A change is accepted once D+1 consecutive synchronized samples
   // disagree with the debounced level; samples reach the decision logic
   // two clocks after they are taken from key_n.
   logic [NK-1:0] m_s1 = '1;
   logic [NK-1:0] m_s2 = '1;
   logic [NK-1:0] m_level = '0;
   int            m_run [NK];
   int            m_hs [NK];
   bit            m_fired [NK];
   logic [NK-1:0] e_press = '0;
   logic [NK-1:0] e_rel = '0;
   logic [NK-1:0] e_long = '0;
   logic [NK-1:0] smp;
   bit            pressed;

   task automatic model_reset();
      m_s1 = '1;
      m_s2 = '1;
      m_level = '0;
      e_press = '0;
      e_rel = '0;
      e_long = '0;
      for (int c = 0; c < NK; c++) begin
         m_run[c] = 0;
         m_hs[c] = 0;
         m_fired[c] = 1'b0;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
         end else begin
            smp = m_s2;
            m_s2 = m_s1;
            m_s1 = kif.key_n;
            e_press = '0;
            e_rel = '0;
            e_long = '0;
            for (int c = 0; c < NK; c++) begin
               pressed = ~smp[c];
               // held-time only accrues while accepted and not mid-release
               if (LONG_EN && m_level[c] && m_run[c] == 0 && !m_fired[c]) begin
                  m_hs[c]++;
                  if (m_hs[c] == L) begin
                     e_long[c] = 1'b1;
                     m_fired[c] = 1'b1;
                  end
               end
               if (pressed != m_level[c]) begin
                  m_run[c]++;
                  if (m_run[c] == D + 1) begin
                     m_level[c] = pressed;
                     m_run[c] = 0;
                     if (pressed) begin
                        e_press[c] = 1'b1;
                        m_hs[c] = 0;
                        m_fired[c] = 1'b0;
                     end else begin
                        e_rel[c] = 1'b1;
                     end
                  end
               end else begin
                  m_run[c] = 0;
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         chk("cyc_press",   32'(kif.key_press),   32'(e_press));
         chk("cyc_release", 32'(kif.key_release), 32'(e_rel));
         chk("cyc_level",   32'(kif.key_level),   32'(m_level));
         chk("cyc_long",    32'(kif.key_long),    32'(e_long));
      end
   end

   // Pulse counters for whole-transaction checks
   int n_press [NK];
   int n_rel [NK];
   int n_long [NK];
   int s_press [NK];
   int s_rel [NK];
   int s_long [NK];

   initial begin
      for (int c = 0; c < NK; c++) begin
         n_press[c] = 0;
         n_rel[c] = 0;
         n_long[c] = 0;
      end
      forever begin
         @(negedge clk);
         for (int c = 0; c < NK; c++) begin
            n_press[c] += int'(kif.key_press[c]);
            n_rel[c]   += int'(kif.key_release[c]);
            n_long[c]  += int'(kif.key_long[c]);
         end
      end
   end

   task automatic snap();
      for (int c = 0; c < NK; c++) begin
         s_press[c] = n_press[c];
         s_rel[c] = n_rel[c];
         s_long[c] = n_long[c];
      end
   endtask

   task automatic chk_counts(input string tag, input int c, input int ep, input int er, input int el);
      #1;
      chk({tag, "_npress"}, n_press[c] - s_press[c], ep);
      chk({tag, "_nrelease"}, n_rel[c] - s_rel[c], er);
      chk({tag, "_nlong"}, n_long[c] - s_long[c], el);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_key(input int c, input logic v);
      kif.key_n[c] = v;
   endtask

   function automatic logic [31:0] all_out();
      return 32'({kif.key_press, kif.key_release, kif.key_level, kif.key_long});
   endfunction

   // ---------------- directed stimulus ----------------
   initial begin
      kif.key_n = '1;
      #1 rst_n = 1'b0;
      step(3);
      chk("reset_outputs", all_out(), 32'h0);
      rst_n = 1'b1;
      step(2);

      // clean press on the reset key, then a long hold
      snap();
      set_key(KEY_RESET, 1'b0);
      step(6);
      chk("t1_press_early", 32'(kif.key_press), 32'h0);
      step(1);
      chk("t1_press", 32'(kif.key_press), 32'b001);
      chk("t1_level", 32'(kif.key_level), 32'b001);
      step(1);
      chk("t1_press_single", 32'(kif.key_press), 32'h0);
      chk("t1_level_hold", 32'(kif.key_level), 32'b001);
      step(8);
      chk("t1_long_early", 32'(kif.key_long), 32'h0);
      step(1);
      chk("t1_long", 32'(kif.key_long), LONG_EN ? 32'b001 : 32'h0);
      step(20);
      chk_counts("t1", KEY_RESET, 1, 0, LONG_EN ? 1 : 0);
      set_key(KEY_RESET, 1'b1);
      step(12);
      chk_counts("t1r", KEY_RESET, 1, 1, LONG_EN ? 1 : 0);
      chk("t1_level_off", 32'(kif.key_level), 32'h0);

      // short bounces on start/pause produce nothing, then a real press
      snap();
      set_key(KEY_START_PAUSE, 1'b0);
      step(3);
      set_key(KEY_START_PAUSE, 1'b1);
      step(1);
      set_key(KEY_START_PAUSE, 1'b0);
      step(3);
      set_key(KEY_START_PAUSE, 1'b1);
      step(10);
      chk_counts("t2_bounce", KEY_START_PAUSE, 0, 0, 0);
      chk("t2_level_quiet", 32'(kif.key_level), 32'h0);
      set_key(KEY_START_PAUSE, 1'b0);
      step(8);
      set_key(KEY_START_PAUSE, 1'b1);
      step(12);
      chk_counts("t2_real", KEY_START_PAUSE, 1, 1, 0);

      // release with bounce on display stop
      snap();
      set_key(KEY_DISPLAY_STOP, 1'b0);
      step(12);
      chk("t3_level_on", 32'(kif.key_level), 32'b100);
      set_key(KEY_DISPLAY_STOP, 1'b1);
      step(2);
      set_key(KEY_DISPLAY_STOP, 1'b0);
      step(1);
      set_key(KEY_DISPLAY_STOP, 1'b1);
      step(6);
      chk("t3_release_early", 32'(kif.key_release), 32'h0);
      chk("t3_level_kept", 32'(kif.key_level), 32'b100);
      step(1);
      chk("t3_release", 32'(kif.key_release), 32'b100);
      chk("t3_level_off", 32'(kif.key_level), 32'h0);
      step(10);
      #1;
      chk("t3_npress", n_press[KEY_DISPLAY_STOP] - s_press[KEY_DISPLAY_STOP], 1);
      chk("t3_nrelease", n_rel[KEY_DISPLAY_STOP] - s_rel[KEY_DISPLAY_STOP], 1);

      // simultaneous presses and releases on two channels
      kif.key_n = 3'b010;
      step(7);
      chk("t4_press_both", 32'(kif.key_press), 32'b101);
      step(1);
      chk("t4_press_gone", 32'(kif.key_press), 32'h0);
      chk("t4_level_both", 32'(kif.key_level), 32'b101);
      kif.key_n = 3'b111;
      step(7);
      chk("t4_release_both", 32'(kif.key_release), 32'b101);
      step(5);

      // reset during a press debounce with another key already held
      set_key(KEY_RESET, 1'b0);
      step(10);
      chk("t5_level_pre", 32'(kif.key_level), 32'b001);
      set_key(KEY_START_PAUSE, 1'b0);
      step(4);
      #2 rst_n = 1'b0;
      #1 chk("t5_reset_now", all_out(), 32'h0);
      step(2);
      rst_n = 1'b1;
      step(6);
      chk("t5_press_early", 32'(kif.key_press), 32'h0);
      step(1);
      chk("t5_press_again", 32'(kif.key_press), 32'b011);
      chk("t5_level_again", 32'(kif.key_level), 32'b011);
      kif.key_n = '1;
      step(12);
      chk("t5_level_final", 32'(kif.key_level), 32'h0);

      step(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
